// File: rtl/uart_tx_device_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_device_if
//  Description : Vermibus slave-side bus bundle for the UART transmitter.
//                valid/address/wstrobe/wdata flow master -> slave,
//                rdata/ready flow slave -> master (both combinational).
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_device_if;
    logic        valid;
    logic [31:0] address;
    logic [3:0]  wstrobe;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;

    modport master (
        output valid, address, wstrobe, wdata,
        input  rdata, ready
    );

    modport slave (
        input  valid, address, wstrobe, wdata,
        output rdata, ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_device.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_device
//  Description : Vermibus UART transmitter (8N1). CPU pushes bytes into a
//                small FIFO through the DATA register; a serial engine drains
//                them LSB first. STATUS/CTRL registers allow polling or a
//                level interrupt when the transmitter has fully drained.
//  Ports       : clk    - system clock
//                reset  - asynchronous active-high reset
//                bus    - Vermibus slave (valid/address/wstrobe/wdata in,
//                         rdata/ready out, combinational responses)
//                tx     - serial output, idle high
//                irq    - transmit-drained interrupt (registered level)
//  Registers   : addr[3:2]=0 DATA (W), 1 STATUS (R), 2 CTRL (R/W), 3 none
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_device #(
    parameter int DIVISOR    = 434,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    uart_tx_device_if.slave  bus,
    output logic             tx,
    output logic             irq
);

    localparam int              c_IDX_W    = $clog2(FIFO_DEPTH);
    localparam int              c_PTR_W    = c_IDX_W + 1;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [15:0]     c_DIV_LAST = 16'(DIVISOR - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [1:0]         r_state;
    logic [15:0]        r_baud;
    logic [2:0]         r_bit;
    logic [7:0]         r_shift;
    logic               r_tx;
    logic               r_irq_en;
    logic               r_irq;

    logic       w_empty;
    logic       w_full;
    logic       w_is_data;
    logic       w_data_wr;
    logic       w_ctrl_wr;
    logic       w_push;
    logic       w_pop;
    logic       w_baud_last;
    logic       w_busy;
    logic [7:0] w_head;
    logic       w_unused;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_PTR_W-1] != r_rd_ptr[c_PTR_W-1]) &&
                     (r_wr_ptr[c_IDX_W-1:0] == r_rd_ptr[c_IDX_W-1:0]);
    assign w_head  = r_mem[r_rd_ptr[c_IDX_W-1:0]];

    assign w_is_data = (bus.address[3:2] == 2'd0);
    assign w_data_wr = bus.valid && w_is_data && bus.wstrobe[0];
    assign w_ctrl_wr = bus.valid && (bus.address[3:2] == 2'd2) && bus.wstrobe[0];

    // Stall only uses registered full, so a slot freed on this edge is only
    // seen by the bus in the following cycle.
    assign bus.ready = bus.valid && !(w_data_wr && w_full);
    assign w_push    = w_data_wr && !w_full;

    assign w_baud_last = (r_baud == c_DIV_LAST);
    assign w_pop = !w_empty &&
                   ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_last));
    assign w_busy = (r_state != S_IDLE);

    assign tx  = r_tx;
    assign irq = r_irq;

    always_comb begin
        bus.rdata = 32'd0;
        case (bus.address[3:2])
            2'd1:    bus.rdata = {29'd0, w_busy, w_empty, w_full};
            2'd2:    bus.rdata = {31'd0, r_irq_en};
            default: bus.rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
    end

    // Storage needs no reset: the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_IDX_W-1:0]] <= bus.wdata[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_baud  <= 16'd0;
            r_bit   <= 3'd0;
            r_shift <= 8'd0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_baud <= 16'd0;
                    if (!w_empty) begin
                        r_shift <= w_head;
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_baud_last) begin
                        r_baud  <= 16'd0;
                        r_tx    <= r_shift[0];
                        r_bit   <= 3'd0;
                        r_state <= S_DATA;
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_baud_last) begin
                        r_baud <= 16'd0;
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            // Bit currently on the line is shift[0]; next is shift[1].
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                            r_bit   <= r_bit + 3'd1;
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                S_STOP: begin
                    if (w_baud_last) begin
                        r_baud <= 16'd0;
                        if (!w_empty) begin
                            // Chain straight into the next start bit.
                            r_shift <= w_head;
                            r_tx    <= 1'b0;
                            r_state <= S_START;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_ctrl_wr) r_irq_en <= bus.wdata[0];
            r_irq <= r_irq_en && w_empty && !w_busy;
        end
    end

    // Bus bits outside the decoded register fields.
    assign w_unused = &{1'b0, bus.address[31:4], bus.address[1:0],
                        bus.wstrobe[3:1], bus.wdata[31:8]};

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_device.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_device
//  Description : Directed self-checking bench for uart_tx_device with
//                DIVISOR=4, FIFO_DEPTH=8. A free-running serial monitor
//                decodes every frame on tx into a byte queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_device;

    localparam int DIV   = 4;
    localparam int DEPTH = 8;

    logic clk;
    logic reset;
    logic tx;
    logic irq;
    int   cyc;
    int   checks;
    int   errors;

    logic [7:0] rx_q [$];
    int         rx_t [$];

    uart_tx_device_if bus ();

    uart_tx_device #(
        .DIVISOR    (DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave),
        .tx    (tx),
        .irq   (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output int waits, output int acc);
        waits = 0;
        @(negedge clk);
        bus.valid   = 1'b1;
        bus.address = a;
        bus.wdata   = d;
        bus.wstrobe = s;
        #1;
        while (!bus.ready && waits < 1000) begin
            @(negedge clk);
            #1;
            waits++;
        end
        check("wr_ready", bus.ready, 1'b1);
        @(posedge clk);
        #1;
        acc         = cyc;
        bus.valid   = 1'b0;
        bus.wstrobe = 4'd0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clk);
        bus.valid   = 1'b1;
        bus.address = a;
        bus.wstrobe = 4'd0;
        #1;
        check("rd_ready", bus.ready, 1'b1);
        d = bus.rdata;
        @(posedge clk);
        #1;
        bus.valid = 1'b0;
    endtask

    task automatic wait_rx(input int n);
        int t;
        t = 0;
        while (rx_q.size() < n && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("rx_count", rx_q.size(), n);
    endtask

    // Serial monitor: samples each bit in the middle of its period.
    initial begin : g_monitor
        logic [7:0] b_v;
        int         st;
        wait (reset == 1'b0);
        forever begin
            @(negedge clk);
            if (tx === 1'b0 && !reset) begin
                st = cyc;
                repeat (DIV / 2) @(negedge clk);
                check("rx_start", tx, 1'b0);
                for (int b = 0; b < 8; b++) begin
                    repeat (DIV) @(negedge clk);
                    b_v[b] = tx;
                end
                repeat (DIV) @(negedge clk);
                check("rx_stop", tx, 1'b1);
                rx_q.push_back(b_v);
                rx_t.push_back(st);
            end
        end
    end

    initial begin : g_watchdog
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : g_main
        logic [31:0] rd;
        logic [31:0] rd2;
        logic [41:0] cap;
        logic [41:0] exp_w;
        logic [9:0]  frame;
        int          w;
        int          acc;
        int          cnt;
        int          waits_a [10];
        int          acc_a   [10];

        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        bus.valid   = 1'b0;
        bus.address = 32'd0;
        bus.wstrobe = 4'd0;
        bus.wdata   = 32'd0;
        #1;
        check("rst_tx", tx, 1'b1);
        check("rst_irq", irq, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        bus_read(32'h4, rd);
        check("rst_status", rd, 32'h2);

        // Reset mid-frame: line returns high at once and stays quiet.
        bus_write(32'h0, 32'h5A, 4'b0001, w, acc);
        repeat (10) @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_tx", tx, 1'b1);
        check("midrst_irq", irq, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bus_read(32'h4, rd);
        check("midrst_status", rd, 32'h2);
        cnt = 0;
        for (int j = 0; j < 50; j++) begin
            @(negedge clk);
            if (tx !== 1'b1) cnt++;
        end
        check("midrst_quiet", cnt, 0);
        rx_q.delete();
        rx_t.delete();

        // Single byte 0x41: exact per-cycle waveform.
        frame = 10'b1_0100_0001_0;   // {stop, data[7:0], start}
        bus_write(32'h0, 32'h41, 4'b0001, w, acc);
        for (int j = 0; j < 42; j++) begin
            @(negedge clk);
            cap[j] = tx;
        end
        for (int j = 0; j < 42; j++)
            exp_w[j] = (j == 0 || j == 41) ? 1'b1 : frame[(j - 1) / DIV];
        check("single_wave", cap, exp_w);
        bus_read(32'h4, rd);
        check("single_status", rd, 32'h2);
        wait_rx(1);
        check("single_byte", rx_q.pop_front(), 8'h41);
        void'(rx_t.pop_front());
        repeat (5) @(negedge clk);

        // Back-to-back: second start bit follows first stop bit directly.
        bus_write(32'h0, 32'h55, 4'b0001, w, acc);
        bus_write(32'h0, 32'hAA, 4'b0001, w, acc);
        wait_rx(2);
        check("b2b_gap", rx_t[1] - rx_t[0], 10 * DIV);
        check("b2b_byte0", rx_q.pop_front(), 8'h55);
        check("b2b_byte1", rx_q.pop_front(), 8'hAA);
        rx_t.delete();
        repeat (5) @(negedge clk);

        // Full stall: 10 writes, 10th waits for the first frame's stop bit.
        for (int i = 0; i < 10; i++)
            bus_write(32'h0, 32'h10 + i, 4'b0001, waits_a[i], acc_a[i]);
        cnt = 0;
        for (int i = 0; i < 9; i++) cnt += waits_a[i];
        check("stall_first9", cnt, 0);
        check("stall_10th_edge", acc_a[9] - acc_a[0], 42);
        wait_rx(10);
        for (int i = 0; i < 10; i++)
            check("stall_order", rx_q.pop_front(), 8'h10 + i);
        rx_t.delete();
        repeat (5) @(negedge clk);

        // Strobes and side-effect-free reads.
        bus_write(32'h0, 32'h77, 4'b0010, w, acc);
        check("strb_nowait", w, 0);
        repeat (50) @(negedge clk);
        check("strb_noframe", rx_q.size(), 0);
        bus_read(32'h0, rd);
        check("data_read", rd, 32'h0);
        bus_write(32'hC, 32'hFFFF_FFFF, 4'b1111, w, acc);
        bus_read(32'hC, rd);
        check("reg3_read", rd, 32'h0);
        bus_read(32'h4, rd);
        bus_read(32'h4, rd2);
        check("status_rd1", rd, 32'h2);
        check("status_rd2", rd2, 32'h2);

        // Interrupt.
        bus_write(32'h8, 32'h1, 4'b0001, w, acc);
        @(negedge clk);
        @(negedge clk);
        check("irq_set", irq, 1'b1);
        bus_read(32'h8, rd);
        check("ctrl_read", rd, 32'h1);
        bus_write(32'h0, 32'h3C, 4'b0001, w, acc);
        @(negedge clk);
        cnt = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (irq !== 1'b0) cnt++;
        end
        check("irq_frame_low", cnt, 0);
        @(negedge clk);
        check("irq_idle_edge", irq, 1'b0);
        @(negedge clk);
        check("irq_reassert", irq, 1'b1);
        bus_write(32'h8, 32'h0, 4'b0001, w, acc);
        @(negedge clk);
        @(negedge clk);
        check("irq_clear", irq, 1'b0);
        wait_rx(1);
        check("irq_byte", rx_q.pop_front(), 8'h3C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_device.md
Name: uart_tx_device

Overview:
Vermibus slave that replaces the bare text-output stub at device address 0x10 with a real serial transmitter. The CPU writes bytes into a small FIFO. An 8N1 transmitter drains the FIFO onto a serial line. Status and control registers let firmware poll, or take an interrupt when the transmitter drains. Upper address decode (address[31:24]) stays outside the block; the block decodes only address[3:2].

Parameters:
DIVISOR, 434, clock cycles per serial bit (legal range 2..65535)
FIFO_DEPTH, 8, FIFO entries (power of two, at least 2)

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
valid  in  1  bus request; already qualified by the external device select
address  in  32  byte address; only [3:2] used
wstrobe  in  4  byte write enables; 0 means read
wdata  in  32  write data
rdata  out  32  read data, combinational
ready  out  1  bus acknowledge, combinational
tx  out  1  serial output, idle high
irq  out  1  transmit-drained interrupt

Behaviour:
- Reset: asynchronous, active-high, on the clk/reset pair. While asserted:
  - tx=1, irq=0, FIFO empty, FSM=IDLE, bit and baud counters 0, ctrl=0.
  - A frame in flight is abandoned; tx returns high immediately.
- Register map (address[3:2]):
  - 0 DATA: write with wstrobe[0]=1 pushes wdata[7:0]; reads return 0.
  - 1 STATUS (read-only): bit0 full, bit1 empty, bit2 busy (FSM != IDLE), bits[31:3]=0.
  - 2 CTRL: bit0 irq_en; write when wstrobe[0]=1; reads return {31'b0, irq_en}.
  - 3: reads return 0; writes ignored.
- Handshake:
  - ready = valid, except for a DATA write with wstrobe[0]=1 while FIFO full; then ready=0 and the bus stalls until a slot frees.
  - ready does not depend combinationally on the same-cycle pop; a slot freed on edge N gives ready=1 in the cycle after N.
  - A push happens on the rising edge where valid && ready && DATA write.
  - A DATA write with wstrobe[0]=0 but wstrobe!=0 completes with no push.
  - Reads never have side effects.
- FIFO: circular buffer with log2(FIFO_DEPTH)+1-bit pointers; full when the MSBs differ and the low bits are equal. Push and pop on the same edge are both legal when the FIFO is non-empty and not full.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop into shift register, tx<=0, baud counter<=0, go to START.
  - START: after DIVISOR cycles, tx<=shift[0], go to DATA with bit index 0.
  - DATA: every DIVISOR cycles, shift right and drive the next bit (LSB first). After bit 7 has been held DIVISOR cycles, tx<=1 and go to STOP.
  - STOP: after DIVISOR cycles:
    - if FIFO non-empty, pop, tx<=0, go to START (back-to-back, no idle gap);
    - otherwise go to IDLE.
- Timing:
  - Write accepted on edge N: entry visible on N+1. If FSM was IDLE with FIFO empty, start bit begins at edge N+1.
  - Frame length is exactly 10*DIVISOR cycles. Baud counter counts 0..DIVISOR-1 and wraps.
- irq: registered; irq = irq_en && FIFO empty && FSM==IDLE. Level-sensitive; cleared by clearing irq_en or by writing a byte.

Test Plan:
- Reset: DIVISOR=4, assert reset mid-frame -> tx=1, irq=0, STATUS read = 0x2 after release, no further transitions on tx.
- Single byte: DIVISOR=4, write 0x41 to DATA -> tx low from edge N+1 for 4 cycles, then bits 1,0,0,0,0,0,1,0 at 4 cycles each, then high for 4 cycles; STATUS=0x2 after 40 cycles.
- Back-to-back: write 0x55 then 0xAA -> second start bit immediately follows the first stop bit; total 80 cycles of activity with no idle gap.
- Full stall: FIFO_DEPTH=8, DIVISOR=4, write 10 bytes without waiting:
  - first 9 complete with ready=valid (one popped immediately);
  - 10th holds ready=0 until the first frame's stop bit ends, then completes;
  - all 10 bytes appear on tx in order.
- Strobe/side effects: write to DATA with wstrobe=4'b0010 -> ready=1, no frame; read DATA -> 0; read STATUS twice -> same value, FIFO unchanged.
- Interrupt: write CTRL=1 with FIFO idle -> irq=1 on next cycle; write byte -> irq=0 through the frame, irq=1 one cycle after return to IDLE; write CTRL=0 -> irq=0.
